// File: rtl/bus_hold_controller.sv
// bus_hold_controller: CPU HOLD/HLDA sequencer with round-robin bus grant; BUS_HOLD_TIMEOUT_EN adds a tenure limit.
module bus_hold_controller #(
    parameter int NUM_REQ = 2,
`ifdef BUS_HOLD_TIMEOUT_EN
    parameter int MAX_TENURE = 64,
`endif
    parameter int MIN_CPU_GAP = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cpu_clock_posedge,
    input  logic [NUM_REQ-1:0] req,
    input  logic               HLDA,
    output logic               HOLD,
    output logic [NUM_REQ-1:0] grant,
    output logic               busy,
    output logic               timeout
);
    localparam int OW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    localparam logic [NUM_REQ-1:0] ONE = 1;
    typedef enum logic [1:0] {IDLE, HOLD_REQ, GRANTED, RELEASE} state_t;
    state_t state, state_n;
    logic [OW-1:0] owner, last_owner, winner, idx;
    logic [3:0] gap;
    logic withdrawn;
    logic expire;
    logic [NUM_REQ-1:0] eligible;
    assign busy = state != IDLE;
    // Scan downward so the nearest set bit after last_owner is the last one assigned.
    always_comb begin
        winner = last_owner;
        idx = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = OW'((int'(last_owner) + i) % NUM_REQ);
            if (eligible[idx]) winner = idx;
        end
    end
    always_comb begin
        state_n = state;
        HOLD = 1'b0;
        grant = '0;
        case (state)
            IDLE: if (cpu_clock_posedge && gap == 4'd0 && |eligible) state_n = HOLD_REQ;
            HOLD_REQ: begin
                HOLD = 1'b1;
                if (cpu_clock_posedge && HLDA) state_n = (withdrawn || !req[owner]) ? RELEASE : GRANTED;
            end
            GRANTED: begin
                HOLD = 1'b1;
                grant[owner] = 1'b1;
                if (!req[owner] || (cpu_clock_posedge && (!HLDA || expire))) state_n = RELEASE;
            end
            default: if (cpu_clock_posedge && !HLDA) state_n = IDLE;
        endcase
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            owner <= '0;
            last_owner <= OW'(NUM_REQ - 1);
            gap <= '0;
            withdrawn <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && state_n == HOLD_REQ) owner <= winner;
            if (state == RELEASE) last_owner <= owner;
            if (state == RELEASE && state_n == IDLE) gap <= 4'(MIN_CPU_GAP);
            else if (state == IDLE && cpu_clock_posedge && gap != 4'd0) gap <= gap - 4'd1;
            withdrawn <= state == HOLD_REQ && (withdrawn || !req[owner]);
        end
    end
`ifdef BUS_HOLD_TIMEOUT_EN
    logic [7:0] tenure;
    logic [NUM_REQ-1:0] mask;
    logic timeout_q;
    logic fire;
    assign expire = tenure <= 8'd1;
    assign fire = state == GRANTED && cpu_clock_posedge && expire && req[owner];
    assign eligible = req & ~mask;
    assign timeout = timeout_q;
    // A timed-out owner stays masked until its request is seen low.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tenure <= '0;
            mask <= '0;
            timeout_q <= 1'b0;
        end else begin
            tenure <= state == HOLD_REQ ? 8'(MAX_TENURE) :
                      (state == GRANTED && cpu_clock_posedge && tenure != 8'd0) ? tenure - 8'd1 : tenure;
            mask <= (mask & req) | (fire ? ONE << owner : '0);
            timeout_q <= fire;
        end
    end
`else
    assign expire = 1'b0;
    assign eligible = req;
    assign timeout = 1'b0;
`endif
endmodule

// File: tb/tb_bus_hold_controller.sv
// tb_bus_hold_controller: directed checks of handshake, round-robin, gap, withdrawal, violation, reset and timeout.
module tb_bus_hold_controller;
    logic clock, reset, cpu_clock_posedge, HLDA, HOLD, busy, timeout;
    logic [1:0] req, grant;
    int n_cmp, n_bad;
    bus_hold_controller #(
        .NUM_REQ(2),
`ifdef BUS_HOLD_TIMEOUT_EN
        .MAX_TENURE(4),
`endif
        .MIN_CPU_GAP(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .cpu_clock_posedge(cpu_clock_posedge),
        .req(req),
        .HLDA(HLDA),
        .HOLD(HOLD),
        .grant(grant),
        .busy(busy),
        .timeout(timeout)
    );
    initial clock = 1'b0;
    always #5 clock = ~clock;
    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic step(input logic s);
        cpu_clock_posedge = s;
        @(negedge clock);
    endtask
    task automatic gap_wait(input string tag);
        step(1);
        check({tag, " gap1 HOLD"}, HOLD, 0);
        step(1);
        check({tag, " gap2 HOLD"}, HOLD, 0);
    endtask
    task automatic tenure(input logic [1:0] exp);
        req = 2'b11;
        HLDA = 0;
        gap_wait("rr");
        step(1);
        check("rr HOLD up", HOLD, 1);
        check("rr no early grant", grant, 0);
        HLDA = 1;
        step(1);
        check("rr grant", grant, exp);
        for (int i = 0; i < 4; i++) step(1);
        check("rr grant held", grant, exp);
        req = 2'b11 & ~exp;
        step(0);
        check("rr grant drop", grant, 0);
        check("rr HOLD drop", HOLD, 0);
        HLDA = 0;
        req = 2'b11;
        step(1);
        check("rr idle", busy, 0);
    endtask
    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1;
        req = 0;
        HLDA = 0;
        cpu_clock_posedge = 0;
        @(negedge clock);
        @(negedge clock);
        check("rst HOLD", HOLD, 0);
        check("rst grant", grant, 0);
        check("rst busy", busy, 0);
        check("rst timeout", timeout, 0);
        reset = 0;
        step(1);
        check("idle no req", busy, 0);
        // single request
        req = 2'b01;
        step(0);
        check("no strobe no HOLD", HOLD, 0);
        step(1);
        check("single HOLD", HOLD, 1);
        check("single busy", busy, 1);
        check("single no grant", grant, 0);
        HLDA = 1;
        step(0);
        check("HLDA needs strobe", grant, 0);
        step(1);
        check("single grant", grant, 2'b01);
        check("single timeout", timeout, 0);
        req = 2'b00;
        step(0);
        check("single grant drop", grant, 0);
        check("single HOLD drop", HOLD, 0);
        check("single release busy", busy, 1);
        HLDA = 0;
        step(1);
        check("single idle", busy, 0);
        // round robin; last owner was 0
        tenure(2'b10);
        tenure(2'b01);
        tenure(2'b10);
        tenure(2'b01);
        // early withdrawal
        req = 2'b01;
        HLDA = 0;
        gap_wait("wd");
        step(1);
        check("wd HOLD", HOLD, 1);
        req = 2'b00;
        step(1);
        check("wd HOLD kept", HOLD, 1);
        check("wd no grant", grant, 0);
        HLDA = 1;
        step(1);
        check("wd no grant after HLDA", grant, 0);
        check("wd HOLD drop", HOLD, 0);
        check("wd release busy", busy, 1);
        HLDA = 0;
        step(1);
        check("wd idle", busy, 0);
        // HLDA violation
        req = 2'b01;
        gap_wait("vio");
        step(1);
        HLDA = 1;
        step(1);
        check("vio grant", grant, 2'b01);
        HLDA = 0;
        step(0);
        check("vio ignored off strobe", grant, 2'b01);
        step(1);
        check("vio grant clear", grant, 0);
        check("vio release busy", busy, 1);
        step(1);
        check("vio idle", busy, 0);
        // reset mid-tenure with requester 1 granted
        req = 2'b10;
        gap_wait("mr");
        step(1);
        HLDA = 1;
        step(1);
        check("mr grant", grant, 2'b10);
        #2 reset = 1;
        #1;
        check("mr async HOLD", HOLD, 0);
        check("mr async grant", grant, 0);
        check("mr async busy", busy, 0);
        req = 2'b11;
        HLDA = 0;
        @(negedge clock);
        reset = 0;
        step(1);
        check("post rst HOLD", HOLD, 1);
        HLDA = 1;
        step(1);
        check("post rst grant 0 first", grant, 2'b01);
        req = 2'b00;
        step(0);
        HLDA = 0;
        step(1);
        check("post rst idle", busy, 0);
`ifdef BUS_HOLD_TIMEOUT_EN
        req = 2'b01;
        gap_wait("to");
        step(1);
        HLDA = 1;
        step(1);
        check("to grant", grant, 2'b01);
        for (int i = 0; i < 3; i++) step(1);
        check("to grant after 3", grant, 2'b01);
        check("to no pulse yet", timeout, 0);
        step(1);
        check("to grant cleared", grant, 0);
        check("to pulse", timeout, 1);
        step(0);
        check("to pulse one clock", timeout, 0);
        HLDA = 0;
        step(1);
        for (int i = 0; i < 4; i++) step(1);
        check("to masked HOLD", HOLD, 0);
        check("to masked busy", busy, 0);
        req = 2'b00;
        step(0);
        req = 2'b01;
        step(1);
        check("to regrant HOLD", HOLD, 1);
`else
        req = 2'b01;
        gap_wait("nt");
        step(1);
        HLDA = 1;
        step(1);
        for (int i = 0; i < 80; i++) step(1);
        check("nt unlimited grant", grant, 2'b01);
        check("nt timeout low", timeout, 0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
